ram_sp_arbiter: RTL and testbench

Round-robin arbiter that shares one single-port write-first block RAM among `NUM_REQ` requesters. Each requester issues read or write requests through a valid/ready handshake and receives a one-cycle-later response carrying the RAM output data. The block sits between the requester ports and the RAM instance, and it is the only driver of the RAM's `en`/`we`/`addr`/`di` inputs.

---
 rtl/ram_arb_pkg.sv | 28 ++
 rtl/ram_sp_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/ram_sp_arbiter.sv | 83 ++++++++
 tb/tb_ram_sp_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the single-port RAM arbiter slice.
//   DEF_NUM_REQ / DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default parameter values
//   MAX_REQ / IDX_W : largest supported requester count and its index width
//   onehot_to_idx   : converts a one-hot grant vector into a binary index
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;

  localparam int MAX_REQ = 8;
  localparam int IDX_W   = $clog2(MAX_REQ);

  // Returns the position of the set bit; an all-zero vector maps to 0,
  // so callers must qualify the result with a separate "any grant" flag.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_sp_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: searches the request vector upward from a priority
// pointer (wrapping modulo N) and grants the first asserted bit.
//   clk, rst_n : clock and asynchronous active-low reset
//   req        : request vector, one bit per requester
//   advance    : a handshake fired this cycle; move the pointer past the winner
//   grant      : one-hot (or zero) grant, purely combinational from req/pointer
// ---------------------------------------------------------------------------
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]    r_ptr;
  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_grantIdx;
  logic [PW-1:0]    w_nextPtr;

  // Rotating priority search. The loop walks offsets from the farthest to the
  // nearest, so the requester closest above the pointer overwrites the rest.
  always_comb begin
    int j;
    j       = 0;
    w_grant = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        w_grant    = '0;
        w_grant[j] = 1'b1;
      end
    end
  end

  assign w_grantIdx = onehot_to_idx(MAX_REQ'(w_grant));

  // Explicit wrap instead of a power-of-two overflow so that non-power-of-two
  // requester counts still rotate correctly.
  assign w_nextPtr = (w_grantIdx == IDX_W'(N - 1)) ? '0 : PW'(w_grantIdx + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= w_nextPtr;
    end
  end

  assign grant = w_grant;

endmodule

// File: rtl/ram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// ram_sp_arbiter
// Shares one single-port write-first RAM among NUM_REQ requesters with
// round-robin arbitration and a fixed one-cycle response.
//   clk, rst_n        : clock and asynchronous active-low reset
//   req_valid/ready   : per-requester handshake (ready is one-hot or zero)
//   req_we/addr/wdata : per-requester payload, flattened per requester slice
//   rsp_valid         : registered one-hot strobe naming the responding requester
//   rsp_rdata         : shared response data, straight from the RAM output
//   ram_en/we/addr/di : RAM port drive, combinational from the granted requester
//   ram_dout          : registered RAM output (write-first)
// ---------------------------------------------------------------------------
module ram_sp_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [DATA_WIDTH-1:0]          ram_di,
  input  logic [DATA_WIDTH-1:0]          ram_dout
);

  logic [NUM_REQ-1:0] w_grant;
  logic               w_advance;
  logic [NUM_REQ-1:0] r_rspValid;

  // The arbiter never withholds a grant, so any grant is a handshake.
  assign w_advance = |w_grant;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rrArbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (w_advance),
    .grant   (w_grant)
  );

  assign req_ready = w_grant;
  assign ram_en    = |req_valid;

  // AND-OR mux of the granted payload; everything reads as zero when idle.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        ram_we   = req_we[i];
        ram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_di   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The RAM answers one cycle after enable, so the grant delayed by one
  // cycle names the owner of the data currently on ram_dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rspValid <= '0;
    end else begin
      r_rspValid <= w_grant;
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_rdata = ram_dout;

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_arbiter
// Directed scenarios followed by a randomised soak. A behavioural write-first
// RAM sits on the arbiter's RAM port; a reference model (flat memory array,
// modulo-arithmetic round-robin and a one-deep pending response) predicts
// every handshake, RAM drive and response.
// ---------------------------------------------------------------------------
module tb_ram_sp_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int SOAK_REQUESTS = 10000;
  localparam int SOAK_MAX_CYCLES = 40000;

  logic                   clk;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     reqValid;
  logic [NUM_REQ-1:0]     reqReady;
  logic [NUM_REQ-1:0]     reqWe;
  logic [NUM_REQ*AW-1:0]  reqAddr;
  logic [NUM_REQ*DW-1:0]  reqWdata;
  logic [NUM_REQ-1:0]     rspValid;
  logic [DW-1:0]          rspRdata;
  logic                   ramEn;
  logic                   ramWe;
  logic [AW-1:0]          ramAddr;
  logic [DW-1:0]          ramDi;
  logic [DW-1:0]          ramDout;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  int            modelPtr;
  bit            pendValid;
  int            pendReq;
  logic [DW-1:0] pendData;
  logic [DW-1:0] refMem [256];
  int            lastGrant;

  ram_sp_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_we    (reqWe),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .rsp_valid (rspValid),
    .rsp_rdata (rspRdata),
    .ram_en    (ramEn),
    .ram_we    (ramWe),
    .ram_addr  (ramAddr),
    .ram_di    (ramDi),
    .ram_dout  (ramDout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port write-first RAM with a registered output.
  initial begin
    logic [DW-1:0] ramMem [256];
    for (int i = 0; i < 256; i++) ramMem[i] = '0;
    ramDout = '0;
    forever begin
      @(posedge clk);
      if (ramEn) begin
        if (ramWe) begin
          ramMem[ramAddr] <= ramDi;
          ramDout         <= ramDi;
        end else begin
          ramDout <= ramMem[ramAddr];
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input bit valid, input bit we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    reqValid[idx]          = valid;
    reqWe[idx]             = we;
    reqAddr[idx*AW +: AW]  = addr;
    reqWdata[idx*DW +: DW] = data;
  endtask

  task automatic clearAll();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 1'b0, '0, '0);
  endtask

  // First asserted valid found walking upward from the pointer, modulo NUM_REQ.
  function automatic int modelWinner(input logic [NUM_REQ-1:0] v, input int p);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic resetModel();
    modelPtr  = 0;
    pendValid = 1'b0;
    pendReq   = 0;
    pendData  = '0;
    lastGrant = -1;
  endtask

  // One clock cycle: inputs are already driven; check at the falling edge,
  // advance the model, then return 1 time unit after the rising edge.
  task automatic stepCycle();
    int g;
    logic [NUM_REQ-1:0] expReady;
    logic [AW-1:0] a;
    @(negedge clk);
    g = modelWinner(reqValid, modelPtr);
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("req_ready", 32'(reqReady), 32'(expReady));
    checkOutput("ram_en", 32'(ramEn), 32'(|reqValid));
    if (g >= 0) begin
      a = reqAddr[g*AW +: AW];
      checkOutput("ram_we", 32'(ramWe), 32'(reqWe[g]));
      checkOutput("ram_addr", 32'(ramAddr), 32'(a));
      checkOutput("ram_di", 32'(ramDi), 32'(reqWdata[g*DW +: DW]));
    end else begin
      a = '0;
      checkOutput("idle ram_we", 32'(ramWe), 32'd0);
      checkOutput("idle ram_addr", 32'(ramAddr), 32'd0);
      checkOutput("idle ram_di", 32'(ramDi), 32'd0);
    end
    checkOutput("rsp_valid", 32'(rspValid), pendValid ? (32'd1 << pendReq) : 32'd0);
    if (pendValid) checkOutput("rsp_rdata", 32'(rspRdata), 32'(pendData));
    if (g >= 0) begin
      pendValid = 1'b1;
      pendReq   = g;
      if (reqWe[g]) begin
        refMem[a] = reqWdata[g*DW +: DW];
        pendData  = reqWdata[g*DW +: DW];
      end else begin
        pendData = refMem[a];
      end
      modelPtr = (g + 1) % NUM_REQ;
    end else begin
      pendValid = 1'b0;
    end
    lastGrant = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waitCycles [NUM_REQ];
    int grants;
    int cycles;

    for (int i = 0; i < 256; i++) refMem[i] = '0;
    resetModel();
    reqValid = '0; reqWe = '0; reqAddr = '0; reqWdata = '0;
    rst_n = 1'b0;

    // Reset state
    #1;
    checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset held rsp_valid", 32'(rspValid), 32'd0);
    rst_n = 1'b1;

    // Full contention: even requesters write, odd ones read the neighbour's word
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i % 2 == 0) applyStimulus(i, 1'b1, 1'b1, AW'(8'h20 + i), DW'(8'h50 + i));
      else            applyStimulus(i, 1'b1, 1'b0, AW'(8'h20 + i - 1), '0);
    end
    for (int k = 0; k < 8; k++) begin
      stepCycle();
      checkOutput("contention grant", 32'(lastGrant), 32'(k % NUM_REQ));
    end
    clearAll();
    stepCycle();

    // Write/read pair on requester 1
    applyStimulus(1, 1'b1, 1'b1, 8'h10, 8'hA5);
    stepCycle();
    checkOutput("wr rsp_valid", 32'(rspValid), 32'b0010);
    checkOutput("wr rsp_rdata", 32'(rspRdata), 32'hA5);
    applyStimulus(1, 1'b1, 1'b0, 8'h10, 8'h00);
    stepCycle();
    checkOutput("rd rsp_valid", 32'(rspValid), 32'b0010);
    checkOutput("rd rsp_rdata", 32'(rspRdata), 32'hA5);
    clearAll();

    // Cross-requester hazard: 2 writes, 3 reads the same address next cycle
    applyStimulus(2, 1'b1, 1'b1, 8'h7F, 8'h3C);
    stepCycle();
    clearAll();
    applyStimulus(3, 1'b1, 1'b0, 8'h7F, 8'h00);
    stepCycle();
    checkOutput("hazard rsp_valid", 32'(rspValid), 32'b1000);
    checkOutput("hazard rsp_rdata", 32'(rspRdata), 32'h3C);
    clearAll();

    // Sparse traffic and pointer wrap
    applyStimulus(3, 1'b1, 1'b0, 8'h10, 8'h00);
    stepCycle();
    checkOutput("wrap grant 3", 32'(lastGrant), 32'd3);
    clearAll();
    applyStimulus(2, 1'b1, 1'b0, 8'h20, 8'h00);
    stepCycle();
    checkOutput("sparse grant 2", 32'(lastGrant), 32'd2);
    clearAll();
    stepCycle();
    stepCycle();
    checkOutput("idle ram_en", 32'(ramEn), 32'd0);
    checkOutput("idle rsp_valid", 32'(rspValid), 32'd0);

    // Reset mid-operation: reads only, so the RAM is untouched during reset
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b1, 1'b0, AW'(8'h20 + i), '0);
    stepCycle();
    stepCycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset rsp_valid", 32'(rspValid), 32'd0);
    resetModel();
    @(posedge clk);
    #1;
    checkOutput("midreset held rsp_valid", 32'(rspValid), 32'd0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post-reset grant", 32'(lastGrant), 32'd0);
    clearAll();
    stepCycle();

    // Randomised soak with stable-until-ready requesters
    for (int i = 0; i < NUM_REQ; i++) waitCycles[i] = 0;
    grants = 0;
    cycles = 0;
    while (grants < SOAK_REQUESTS && cycles < SOAK_MAX_CYCLES) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!reqValid[i] && ($urandom_range(0, 9) < 6)) begin
          applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)),
                        AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
        end
      end
      stepCycle();
      cycles++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (lastGrant == i) begin
          checkOutput("starvation bound", 32'(waitCycles[i] <= NUM_REQ - 1), 32'd1);
          waitCycles[i] = 0;
          applyStimulus(i, 1'b0, 1'b0, '0, '0);
          grants++;
        end else if (reqValid[i]) begin
          waitCycles[i]++;
        end
      end
    end
    checkOutput("soak completed", 32'(grants >= SOAK_REQUESTS), 32'd1);
    clearAll();
    stepCycle();
    stepCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
